// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-read, dual-write register file with busy scoreboard.
// Holds default sizes, the busy_cnt width helper and the read-port bypass priority select.
// No ports; imported by regfile_sb_if, rf_scoreboard and regfile_sb.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  // busy_cnt must be able to hold NREGS itself (every register busy).
  function automatic int busy_cnt_w(input int nregs);
    return $clog2(nregs + 1);
  endfunction

  localparam int BUSY_CNT_W_DEF = busy_cnt_w(NREGS_DEF);

  // Where a read port takes its data from this cycle.
  typedef enum logic [1:0] {
    SRC_ARRAY = 2'd0,
    SRC_WR0   = 2'd1,
    SRC_WR1   = 2'd2
  } rd_src_e;

  // Port-priority mux select: the load port (wr1) beats the ALU port (wr0),
  // matching the array's own write-collision rule.
  function automatic rd_src_e bypass_sel(input logic hit0, input logic hit1);
    if (hit1) begin
      return SRC_WR1;
    end
    if (hit0) begin
      return SRC_WR0;
    end
    return SRC_ARRAY;
  endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Bundle of read, write, issue and busy-count signals between decode/writeback and the register file.
// Latency and backpressure are properties of regfile_sb; the interface itself is pure wiring.
// Signals: rd_addr/rd_data/rd_busy (NRD read ports), wr0_*/wr1_* write ports, iss_* issue port, busy_cnt.
interface regfile_sb_if
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2
);

  localparam int AW = $clog2(NREGS);
  localparam int CW = busy_cnt_w(NREGS);

  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;

  logic                wr0_en;
  logic [AW-1:0]       wr0_addr;
  logic [XLEN-1:0]     wr0_data;

  logic                wr1_en;
  logic [AW-1:0]       wr1_addr;
  logic [XLEN-1:0]     wr1_data;

  logic                iss_en;
  logic [AW-1:0]       iss_addr;

  logic [CW-1:0]       busy_cnt;

  // Pipeline side (decode + writeback) drives requests.
  modport master (
    output rd_addr, wr0_en, wr0_addr, wr0_data,
    output wr1_en, wr1_addr, wr1_data, iss_en, iss_addr,
    input  rd_data, rd_busy, busy_cnt
  );

  // Register file side.
  modport slave (
    input  rd_addr, wr0_en, wr0_addr, wr0_data,
    input  wr1_en, wr1_addr, wr1_data, iss_en, iss_addr,
    output rd_data, rd_busy, busy_cnt
  );

endinterface

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: issue sets, writeback clears, set wins on the same address; busy_cnt registered.
// Latency: busy bits and busy_cnt reflect an edge's updates right after that edge.
// No backpressure; out-of-range and (ZERO_REG) x0 addresses never become busy.
// Ports: clk, rst (async active-low), i_wr0_*/i_wr1_* clears, i_iss_* set, o_busy vector, o_busy_cnt.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS    = NREGS_DEF,
  parameter int AW       = $clog2(NREGS),
  parameter int ZERO_REG = 1,
  parameter int CNT_W    = BUSY_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr0_en,
  input  logic [AW-1:0]    i_wr0_addr,
  input  logic             i_wr1_en,
  input  logic [AW-1:0]    i_wr1_addr,
  input  logic             i_iss_en,
  input  logic [AW-1:0]    i_iss_addr,
  output logic [NREGS-1:0] o_busy,
  output logic [CNT_W-1:0] o_busy_cnt
);

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_nxt;
  logic [CNT_W-1:0] r_busy_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  // Addresses >= NREGS never match any index here, so they fall out naturally.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int i = 0; i < NREGS; i++) begin
      if ((i_wr0_en && (i_wr0_addr == AW'(i))) ||
          (i_wr1_en && (i_wr1_addr == AW'(i)))) begin
        w_busy_nxt[i] = 1'b0;
      end
      // Applied after the clear so a same-cycle issue keeps the register busy.
      if (i_iss_en && (i_iss_addr == AW'(i))) begin
        w_busy_nxt[i] = 1'b1;
      end
    end
    if (ZERO_REG != 0) begin
      w_busy_nxt[0] = 1'b0;
    end
  end

  // Count the post-update vector so busy_cnt always agrees with o_busy.
  always_comb begin
    w_cnt_nxt = '0;
    for (int i = 0; i < NREGS; i++) begin
      w_cnt_nxt = w_cnt_nxt + CNT_W'(w_busy_nxt[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      r_busy     <= w_busy_nxt;
      r_busy_cnt <= w_cnt_nxt;
    end
  end

  assign o_busy     = r_busy;
  assign o_busy_cnt = r_busy_cnt;

endmodule

// File: rtl/regfile_sb.sv
// Multi-read, dual-write register file with busy scoreboard; wr1 (load) beats wr0 (ALU) on collision.
// Latency: reads combinational (SYNC_READ=0) or registered one cycle (SYNC_READ=1); optional write bypass.
// No backpressure: every enabled write/issue is taken on the rising edge.
// Ports: clk, rst (async active-low), bus (regfile_sb_if.slave: read ports, two write ports, issue, busy_cnt).
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int NREGS     = NREGS_DEF,
  parameter int NRD       = 2,
  parameter int ZERO_REG  = 1,
  parameter int BYPASS    = 1,
  parameter int SYNC_READ = 0
) (
  input  logic        clk,
  input  logic        rst,
  regfile_sb_if.slave bus
);

  localparam int AW = $clog2(NREGS);
  localparam int CW = busy_cnt_w(NREGS);
  // One extra bit so the range check also works when NREGS is a power of two.
  localparam logic [AW:0] NREGS_W = (AW + 1)'(NREGS);

  logic [XLEN-1:0]  r_mem [NREGS];
  logic [NREGS-1:0] w_busy;
  logic [CW-1:0]    w_busy_cnt;

  // Data array. wr1 is checked first so it wins a same-address collision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (!((ZERO_REG != 0) && (i == 0))) begin
          if (bus.wr1_en && (bus.wr1_addr == AW'(i))) begin
            r_mem[i] <= bus.wr1_data;
          end else if (bus.wr0_en && (bus.wr0_addr == AW'(i))) begin
            r_mem[i] <= bus.wr0_data;
          end
        end
      end
    end
  end

  rf_scoreboard #(
    .NREGS    (NREGS),
    .AW       (AW),
    .ZERO_REG (ZERO_REG),
    .CNT_W    (CW)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .i_wr0_en   (bus.wr0_en),
    .i_wr0_addr (bus.wr0_addr),
    .i_wr1_en   (bus.wr1_en),
    .i_wr1_addr (bus.wr1_addr),
    .i_iss_en   (bus.iss_en),
    .i_iss_addr (bus.iss_addr),
    .o_busy     (w_busy),
    .o_busy_cnt (w_busy_cnt)
  );

  assign bus.busy_cnt = w_busy_cnt;

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0]   w_addr;
    logic            w_in_range;
    logic            w_masked;
    logic            w_hit0;
    logic            w_hit1;
    rd_src_e         w_src;
    logic [XLEN-1:0] w_data;
    logic            w_busy_bit;

    assign w_addr     = bus.rd_addr[p*AW +: AW];
    assign w_in_range = ({1'b0, w_addr} < NREGS_W);
    // Out-of-range and hard-wired x0 reads are forced to zero / not busy.
    assign w_masked   = !w_in_range || ((ZERO_REG != 0) && (w_addr == '0));
    assign w_hit0     = (BYPASS != 0) && bus.wr0_en && (bus.wr0_addr == w_addr);
    assign w_hit1     = (BYPASS != 0) && bus.wr1_en && (bus.wr1_addr == w_addr);
    assign w_src      = bypass_sel(w_hit0, w_hit1);

    always_comb begin
      w_data     = '0;
      w_busy_bit = 1'b0;
      if (!w_masked) begin
        case (w_src)
          SRC_WR1: w_data = bus.wr1_data;
          SRC_WR0: w_data = bus.wr0_data;
          default: w_data = r_mem[w_addr];
        endcase
        // A register being written back this cycle already has its value on the bypass.
        w_busy_bit = w_busy[w_addr] && !(w_hit0 || w_hit1);
      end
    end

    if (SYNC_READ != 0) begin : g_sync
      logic [XLEN-1:0] r_data;
      logic            r_busy;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_data <= '0;
          r_busy <= 1'b0;
        end else begin
          r_data <= w_data;
          r_busy <= w_busy_bit;
        end
      end

      assign bus.rd_data[p*XLEN +: XLEN] = r_data;
      assign bus.rd_busy[p]              = r_busy;
    end else begin : g_comb
      assign bus.rd_data[p*XLEN +: XLEN] = w_data;
      assign bus.rd_busy[p]              = w_busy_bit;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: three instances share one stimulus stream
// (a: 32 regs bypass comb read, b: 32 regs no bypass, c: 20 regs bypass registered read).
// A register-array reference model predicts every read, busy bit and busy count.
module tb_regfile_sb;

  localparam int XLEN = 32;
  localparam int NRD  = 2;
  localparam int AW   = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NRD*AW-1:0] rd_addr;
  logic              wr0_en, wr1_en, iss_en;
  logic [AW-1:0]     wr0_addr, wr1_addr, iss_addr;
  logic [XLEN-1:0]   wr0_data, wr1_data;

  regfile_sb_if #(.XLEN(XLEN), .NREGS(32), .NRD(NRD)) if_a ();
  regfile_sb_if #(.XLEN(XLEN), .NREGS(32), .NRD(NRD)) if_b ();
  regfile_sb_if #(.XLEN(XLEN), .NREGS(20), .NRD(NRD)) if_c ();

  assign if_a.rd_addr = rd_addr;   assign if_b.rd_addr = rd_addr;   assign if_c.rd_addr = rd_addr;
  assign if_a.wr0_en = wr0_en;     assign if_b.wr0_en = wr0_en;     assign if_c.wr0_en = wr0_en;
  assign if_a.wr0_addr = wr0_addr; assign if_b.wr0_addr = wr0_addr; assign if_c.wr0_addr = wr0_addr;
  assign if_a.wr0_data = wr0_data; assign if_b.wr0_data = wr0_data; assign if_c.wr0_data = wr0_data;
  assign if_a.wr1_en = wr1_en;     assign if_b.wr1_en = wr1_en;     assign if_c.wr1_en = wr1_en;
  assign if_a.wr1_addr = wr1_addr; assign if_b.wr1_addr = wr1_addr; assign if_c.wr1_addr = wr1_addr;
  assign if_a.wr1_data = wr1_data; assign if_b.wr1_data = wr1_data; assign if_c.wr1_data = wr1_data;
  assign if_a.iss_en = iss_en;     assign if_b.iss_en = iss_en;     assign if_c.iss_en = iss_en;
  assign if_a.iss_addr = iss_addr; assign if_b.iss_addr = iss_addr; assign if_c.iss_addr = iss_addr;

  regfile_sb #(.XLEN(XLEN), .NREGS(32), .NRD(NRD), .ZERO_REG(1), .BYPASS(1), .SYNC_READ(0))
    u_dut (.clk(clk), .rst(rst), .bus(if_a));
  regfile_sb #(.XLEN(XLEN), .NREGS(32), .NRD(NRD), .ZERO_REG(1), .BYPASS(0), .SYNC_READ(0))
    u_nb  (.clk(clk), .rst(rst), .bus(if_b));
  regfile_sb #(.XLEN(XLEN), .NREGS(20), .NRD(NRD), .ZERO_REG(1), .BYPASS(1), .SYNC_READ(1))
    u_sr  (.clk(clk), .rst(rst), .bus(if_c));

  // Reference model: index 0 = 32-register file, index 1 = 20-register file.
  logic [31:0] m_mem  [2][32];
  bit          m_busy [2][32];
  int          m_lim  [2] = '{32, 20};
  logic [31:0] sr_d [NRD];
  logic        sr_b [NRD];

  int n_checks = 0;
  int n_pass   = 0;

  function automatic int ra(int p);
    return int'(rd_addr[p*AW +: AW]);
  endfunction

  function automatic logic [31:0] exp_data(int c, int a, bit byp);
    if (a == 0 || a >= m_lim[c]) return 32'h0;
    if (byp && wr1_en && int'(wr1_addr) == a) return wr1_data;
    if (byp && wr0_en && int'(wr0_addr) == a) return wr0_data;
    return m_mem[c][a];
  endfunction

  function automatic logic exp_busy(int c, int a, bit byp);
    if (a == 0 || a >= m_lim[c]) return 1'b0;
    if (byp && ((wr0_en && int'(wr0_addr) == a) || (wr1_en && int'(wr1_addr) == a))) return 1'b0;
    return m_busy[c][a];
  endfunction

  function automatic int exp_cnt(int c);
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(m_busy[c][i]);
    return n;
  endfunction

  function automatic void model_edge(int c);
    int a0 = int'(wr0_addr);
    int a1 = int'(wr1_addr);
    int ai = int'(iss_addr);
    if (wr0_en && a0 != 0 && a0 < m_lim[c]) begin m_mem[c][a0] = wr0_data; m_busy[c][a0] = 1'b0; end
    if (wr1_en && a1 != 0 && a1 < m_lim[c]) begin m_mem[c][a1] = wr1_data; m_busy[c][a1] = 1'b0; end
    if (iss_en && ai != 0 && ai < m_lim[c]) m_busy[c][ai] = 1'b1;
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 32; i++) begin m_mem[c][i] = 32'h0; m_busy[c][i] = 1'b0; end
    for (int p = 0; p < NRD; p++) begin sr_d[p] = 32'h0; sr_b[p] = 1'b0; end
  endfunction

  task automatic idle();
    wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0;
    wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
    iss_en = 1'b0; iss_addr = '0; rd_addr = '0;
  endtask

  task automatic set_rd(int p, int a);
    rd_addr[p*AW +: AW] = AW'(a);
  endtask

  // Advance one clock: latch what the registered-read instance should capture, then update the model.
  task automatic tick();
    for (int p = 0; p < NRD; p++) begin
      sr_d[p] = rst ? exp_data(1, ra(p), 1'b1) : 32'h0;
      sr_b[p] = rst ? exp_busy(1, ra(p), 1'b1) : 1'b0;
    end
    @(posedge clk);
    if (rst) begin model_edge(0); model_edge(1); end
    #1;
  endtask

  task automatic test_reset();
    idle(); set_rd(0, 5);
    #1 rst = 1'b0;
    model_reset();
    #7;
    n_checks++; if (if_a.busy_cnt !== 6'd0) $display("FAIL rst_cnt_a got %0d want 0", if_a.busy_cnt); else n_pass++;
    n_checks++; if (if_c.rd_data !== 64'h0) $display("FAIL rst_sync_data got %h want 0", if_c.rd_data); else n_pass++;
    n_checks++; if (if_c.rd_busy !== 2'b00) $display("FAIL rst_sync_busy got %b want 00", if_c.rd_busy); else n_pass++;
    n_checks++; if (if_c.busy_cnt !== 5'd0) $display("FAIL rst_cnt_c got %0d want 0", if_c.busy_cnt); else n_pass++;
    rst = 1'b1;
    wr0_en = 1'b1; wr0_addr = 5; wr0_data = 32'hDEAD_BEEF; iss_en = 1'b1; iss_addr = 6;
    tick();
    idle(); set_rd(0, 5); #2;
    n_checks++; if (if_a.rd_data[31:0] !== 32'hDEAD_BEEF) $display("FAIL rst_pre_x5 got %h want deadbeef", if_a.rd_data[31:0]); else n_pass++;
    n_checks++; if (if_a.busy_cnt !== 6'd1) $display("FAIL rst_pre_cnt got %0d want 1", if_a.busy_cnt); else n_pass++;
    rst = 1'b0; #1;
    model_reset();
    n_checks++; if (if_a.rd_data[31:0] !== 32'h0) $display("FAIL rst_async_x5 got %h want 0", if_a.rd_data[31:0]); else n_pass++;
    n_checks++; if (if_a.busy_cnt !== 6'd0) $display("FAIL rst_async_cnt got %0d want 0", if_a.busy_cnt); else n_pass++;
    n_checks++; if (if_a.rd_busy !== 2'b00) $display("FAIL rst_async_busy got %b want 00", if_a.rd_busy); else n_pass++;
    #1 rst = 1'b1;
  endtask

  task automatic test_collision();
    idle();
    wr0_en = 1'b1; wr0_addr = 7; wr0_data = 32'h11;
    wr1_en = 1'b1; wr1_addr = 7; wr1_data = 32'h22;
    set_rd(1, 7); #2;
    n_checks++; if (if_a.rd_data[63:32] !== 32'h22) $display("FAIL coll_bypass got %h want 22", if_a.rd_data[63:32]); else n_pass++;
    n_checks++; if (if_b.rd_data[63:32] !== 32'h0) $display("FAIL coll_nobypass got %h want 0", if_b.rd_data[63:32]); else n_pass++;
    tick();
    idle(); set_rd(0, 7); #2;
    n_checks++; if (if_a.rd_data[31:0] !== 32'h22) $display("FAIL coll_x7 got %h want 22", if_a.rd_data[31:0]); else n_pass++;
    n_checks++; if (if_b.rd_data[31:0] !== 32'h22) $display("FAIL coll_x7_b got %h want 22", if_b.rd_data[31:0]); else n_pass++;
    tick();
    n_checks++; if (if_c.rd_data[31:0] !== 32'h22) $display("FAIL coll_x7_sync got %h want 22", if_c.rd_data[31:0]); else n_pass++;
  endtask

  task automatic test_bypass();
    idle(); wr0_en = 1'b1; wr0_addr = 3; wr0_data = 32'hAA; tick();
    idle(); wr0_en = 1'b1; wr0_addr = 3; wr0_data = 32'h55; set_rd(0, 3); #2;
    n_checks++; if (if_a.rd_data[31:0] !== 32'h55) $display("FAIL byp_fwd got %h want 55", if_a.rd_data[31:0]); else n_pass++;
    n_checks++; if (if_b.rd_data[31:0] !== 32'hAA) $display("FAIL byp_off_old got %h want aa", if_b.rd_data[31:0]); else n_pass++;
    tick();
    n_checks++; if (if_c.rd_data[31:0] !== 32'h55) $display("FAIL byp_sync got %h want 55", if_c.rd_data[31:0]); else n_pass++;
  endtask

  task automatic test_scoreboard();
    idle(); iss_en = 1'b1; iss_addr = 9; tick();
    idle(); set_rd(0, 9); #2;
    n_checks++; if (if_a.rd_busy[0] !== 1'b1) $display("FAIL sb_iss_busy got %b want 1", if_a.rd_busy[0]); else n_pass++;
    n_checks++; if (if_a.busy_cnt !== 6'd1) $display("FAIL sb_iss_cnt got %0d want 1", if_a.busy_cnt); else n_pass++;
    wr1_en = 1'b1; wr1_addr = 9; wr1_data = 32'h40; #2;
    n_checks++; if (if_a.rd_busy[0] !== 1'b0) $display("FAIL sb_clr_fwd got %b want 0", if_a.rd_busy[0]); else n_pass++;
    n_checks++; if (if_b.rd_busy[0] !== 1'b1) $display("FAIL sb_clr_nobyp got %b want 1", if_b.rd_busy[0]); else n_pass++;
    tick();
    idle(); set_rd(0, 9); #1;
    n_checks++; if (if_a.busy_cnt !== 6'd0) $display("FAIL sb_clr_cnt got %0d want 0", if_a.busy_cnt); else n_pass++;
    n_checks++; if (if_b.rd_busy[0] !== 1'b0 || if_b.rd_data[31:0] !== 32'h40)
      $display("FAIL sb_clr_x9 got busy %b data %h want 0 40", if_b.rd_busy[0], if_b.rd_data[31:0]); else n_pass++;
    iss_en = 1'b1; iss_addr = 9; wr0_en = 1'b1; wr0_addr = 9; wr0_data = 32'h77; tick();
    idle(); set_rd(0, 9); #1;
    n_checks++; if (if_a.rd_busy[0] !== 1'b1) $display("FAIL sb_setwins_busy got %b want 1", if_a.rd_busy[0]); else n_pass++;
    n_checks++; if (if_a.rd_data[31:0] !== 32'h77) $display("FAIL sb_setwins_data got %h want 77", if_a.rd_data[31:0]); else n_pass++;
    n_checks++; if (if_a.busy_cnt !== 6'd1) $display("FAIL sb_setwins_cnt got %0d want 1", if_a.busy_cnt); else n_pass++;
    wr0_en = 1'b1; wr0_addr = 9; wr0_data = 32'h78; tick();
  endtask

  task automatic test_x0();
    idle(); iss_en = 1'b1; iss_addr = 12; tick();
    idle(); wr0_en = 1'b1; wr0_addr = 0; wr0_data = 32'hFFFF_FFFF; iss_en = 1'b1; iss_addr = 0; set_rd(0, 0); #2;
    n_checks++; if (if_a.rd_data[31:0] !== 32'h0 || if_a.rd_busy[0] !== 1'b0)
      $display("FAIL x0_same got %h/%b want 0/0", if_a.rd_data[31:0], if_a.rd_busy[0]); else n_pass++;
    tick();
    idle(); set_rd(0, 0); #1;
    n_checks++; if (if_a.rd_data[31:0] !== 32'h0 || if_a.rd_busy[0] !== 1'b0)
      $display("FAIL x0_after got %h/%b want 0/0", if_a.rd_data[31:0], if_a.rd_busy[0]); else n_pass++;
    n_checks++; if (if_a.busy_cnt !== 6'd1) $display("FAIL x0_cnt got %0d want 1", if_a.busy_cnt); else n_pass++;
    wr1_en = 1'b1; wr1_addr = 12; wr1_data = 32'h12; tick();
  endtask

  task automatic test_out_of_range();
    idle(); wr0_en = 1'b1; wr0_addr = 25; wr0_data = 32'h00C0_FFEE; iss_en = 1'b1; iss_addr = 22; tick();
    idle(); set_rd(0, 25); set_rd(1, 22); tick();
    n_checks++; if (if_c.rd_data !== 64'h0 || if_c.rd_busy !== 2'b00)
      $display("FAIL oor_read got %h/%b want 0/00", if_c.rd_data, if_c.rd_busy); else n_pass++;
    n_checks++; if (if_c.busy_cnt !== 5'd0) $display("FAIL oor_cnt_c got %0d want 0", if_c.busy_cnt); else n_pass++;
    n_checks++; if (if_a.rd_data[31:0] !== 32'h00C0_FFEE || if_a.rd_busy[1] !== 1'b1 || if_a.busy_cnt !== 6'd1)
      $display("FAIL oor_big got %h/%b/%0d want c0ffee/1/1", if_a.rd_data[31:0], if_a.rd_busy[1], if_a.busy_cnt); else n_pass++;
    idle(); wr0_en = 1'b1; wr0_addr = 22; wr0_data = 32'h22; tick();
  endtask

  task automatic test_sync_read();
    idle(); wr1_en = 1'b1; wr1_addr = 4; wr1_data = 32'h1234; tick();
    idle(); set_rd(0, 4); tick();
    n_checks++; if (if_c.rd_data[31:0] !== 32'h1234) $display("FAIL sync_lat got %h want 1234", if_c.rd_data[31:0]); else n_pass++;
    wr0_en = 1'b1; wr0_addr = 4; wr0_data = 32'h4444; #2;
    n_checks++; if (if_c.rd_data[31:0] !== 32'h1234) $display("FAIL sync_hold got %h want 1234", if_c.rd_data[31:0]); else n_pass++;
    tick();
    n_checks++; if (if_c.rd_data[31:0] !== 32'h4444) $display("FAIL sync_byp got %h want 4444", if_c.rd_data[31:0]); else n_pass++;
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(0, 4) == 0) return AW'($urandom_range(0, 31));
    return AW'($urandom_range(0, 23));
  endfunction

  task automatic test_random();
    int pick;
    for (int cyc = 0; cyc < 400; cyc++) begin
      wr0_en = 1'($urandom_range(0, 1)); wr0_addr = rnd_addr(); wr0_data = $urandom();
      wr1_en = 1'($urandom_range(0, 1)); wr1_addr = rnd_addr(); wr1_data = $urandom();
      iss_en = ($urandom_range(0, 3) == 0); iss_addr = rnd_addr();
      for (int p = 0; p < NRD; p++) begin
        pick = $urandom_range(0, 3);
        set_rd(p, (pick == 0) ? int'(wr0_addr) : (pick == 1) ? int'(wr1_addr) : int'(rnd_addr()));
      end
      #2;
      for (int p = 0; p < NRD; p++) begin
        n_checks++;
        if (if_a.rd_data[p*XLEN +: XLEN] !== exp_data(0, ra(p), 1'b1) || if_a.rd_busy[p] !== exp_busy(0, ra(p), 1'b1))
          $display("FAIL rnd_a cyc %0d port %0d got %h/%b want %h/%b", cyc, p, if_a.rd_data[p*XLEN +: XLEN],
                   if_a.rd_busy[p], exp_data(0, ra(p), 1'b1), exp_busy(0, ra(p), 1'b1));
        else n_pass++;
        n_checks++;
        if (if_b.rd_data[p*XLEN +: XLEN] !== exp_data(0, ra(p), 1'b0) || if_b.rd_busy[p] !== exp_busy(0, ra(p), 1'b0))
          $display("FAIL rnd_b cyc %0d port %0d got %h/%b want %h/%b", cyc, p, if_b.rd_data[p*XLEN +: XLEN],
                   if_b.rd_busy[p], exp_data(0, ra(p), 1'b0), exp_busy(0, ra(p), 1'b0));
        else n_pass++;
      end
      tick();
      n_checks++; if (if_a.busy_cnt !== 6'(exp_cnt(0))) $display("FAIL rnd_cnt_a cyc %0d got %0d want %0d", cyc, if_a.busy_cnt, exp_cnt(0)); else n_pass++;
      n_checks++; if (if_b.busy_cnt !== 6'(exp_cnt(0))) $display("FAIL rnd_cnt_b cyc %0d got %0d want %0d", cyc, if_b.busy_cnt, exp_cnt(0)); else n_pass++;
      n_checks++; if (if_c.busy_cnt !== 5'(exp_cnt(1))) $display("FAIL rnd_cnt_c cyc %0d got %0d want %0d", cyc, if_c.busy_cnt, exp_cnt(1)); else n_pass++;
      for (int p = 0; p < NRD; p++) begin
        n_checks++;
        if (if_c.rd_data[p*XLEN +: XLEN] !== sr_d[p] || if_c.rd_busy[p] !== sr_b[p])
          $display("FAIL rnd_sync cyc %0d port %0d got %h/%b want %h/%b", cyc, p, if_c.rd_data[p*XLEN +: XLEN],
                   if_c.rd_busy[p], sr_d[p], sr_b[p]);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_collision();
    test_bypass();
    test_scoreboard();
    test_x0();
    test_out_of_range();
    test_sync_read();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
